// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings for the HI/LO multiply/divide unit
//
// Purpose: op codes, FSM state codes and the op field width used by
//          hilo_muldiv and hilo_iter_core.
// Ports:   none (package).
package hilo_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_iter_core.sv
// rtl/hilo_iter_core.sv - one-bit-per-cycle shift/add multiplier and restoring divider
//
// Purpose: unsigned iterative datapath; the top level supplies magnitudes
//          and applies sign fix-up.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load            latch a_mag/b_mag/is_div and clear the iteration counter
//   step            perform one iteration this cycle
//   is_div          1 = restoring divide, 0 = shift/add multiply
//   a_mag, b_mag    multiplicand/dividend, multiplier/divisor magnitudes
//   res_valid       one-cycle pulse during the final iteration
//   res_hi, res_lo  result of the current iteration (product high/low, or
//                   remainder/quotient); valid when res_valid is high
module hilo_iter_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          is_div,
  input  logic [DW-1:0] a_mag,
  input  logic [DW-1:0] b_mag,
  output logic          res_valid,
  output logic [DW-1:0] res_hi,
  output logic [DW-1:0] res_lo
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_b;
  logic          mode_div;
  logic [CW-1:0] cnt;

  logic [DW:0]   sum;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic [DW-1:0] nxt_hi;
  logic [DW-1:0] nxt_lo;

  // Multiply: {r_hi, r_lo} starts as {0, multiplier}; each step adds the
  // multiplicand into the high half when the low bit is set, then shifts
  // the whole pair right, keeping the carry.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out of
  // the top and quotient bits in at the bottom. A zero divisor naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    shifted = {r_hi, r_lo[DW-1]};
    diff    = shifted - {1'b0, r_b};
    nxt_hi  = r_hi;
    nxt_lo  = r_lo;
    if (mode_div) begin
      if (shifted >= {1'b0, r_b}) begin
        nxt_hi = diff[DW-1:0];
        nxt_lo = {r_lo[DW-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[DW-1:0];
        nxt_lo = {r_lo[DW-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[DW:1];
      nxt_lo = {sum[0], r_lo[DW-1:1]};
    end
  end

  assign res_valid = step && (cnt == CW'(DW - 1));
  assign res_hi    = nxt_hi;
  assign res_lo    = nxt_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      mode_div <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      r_hi     <= '0;
      r_lo     <= a_mag;
      r_b      <= b_mag;
      mode_div <= is_div;
      cnt      <= '0;
    end else if (step) begin
      r_hi     <= nxt_hi;
      r_lo     <= nxt_lo;
      cnt      <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative multiply/divide engine
//
// Purpose: owns the IDLE/MUL/DIV/DONE FSM, operand sign handling, result
//          sign fix-up, optional multiply-accumulate and the HI/LO registers.
// Optional feature: define HILO_MUL_ACC_EN to enable MADD/MADDU/MSUB/MSUBU
//          (op 1xx); without it, a start with op[2] set is ignored.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, op         issue request and operation code
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   cancel            pipeline flush: abort in-flight operation
//   whi, wlo          MTHI/MTLO write enables
//   hi_i, lo_i        MTHI/MTLO data
//   busy              operation in progress
//   done              one-cycle pulse after HI/LO take the result
//   hi_o, lo_o        HI and LO registers
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   src_a,
  input  logic [DW-1:0]   src_b,
  input  logic            cancel,
  input  logic            whi,
  input  logic            wlo,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o
);

  state_e state_q, state_d;

  logic          op_ok;
  logic          accept;
  logic          op_signed;
  logic          op_is_div;
  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;

  // Operation attributes captured at the accepting edge.
  logic neg_q;       // product / quotient sign
  logic rem_neg_q;   // remainder takes the dividend's sign
  logic div_zero_q;

  logic          core_valid;
  logic [DW-1:0] core_hi;
  logic [DW-1:0] core_lo;
  logic          complete;

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic [DW-1:0]   res_hi;
  logic [DW-1:0]   res_lo;

`ifdef HILO_MUL_ACC_EN
  logic acc_q;
  logic sub_q;
  logic [2*DW-1:0] acc_val;

  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[2];
`endif

  assign op_signed = ~op[0];
  assign op_is_div = ~op[2] & op[1];
  assign a_neg     = op_signed & src_a[DW-1];
  assign b_neg     = op_signed & src_b[DW-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  assign busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done     = (state_q == ST_DONE);
  assign accept   = start & ~cancel & op_ok &
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign complete = core_valid & ~cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept)               state_d = op_is_div ? ST_DIV : ST_MUL;
          else if (state_q == ST_DONE) state_d = ST_IDLE;
        end
        ST_MUL, ST_DIV: begin
          if (core_valid) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      neg_q      <= a_neg ^ b_neg;
      rem_neg_q  <= a_neg;
      div_zero_q <= (src_b == '0);
    end
  end

`ifdef HILO_MUL_ACC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (accept) begin
      acc_q <= op[2];
      sub_q <= op[2] & op[1];
    end
  end
`endif

  hilo_iter_core #(.DW(DW)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (busy),
    .is_div    (op_is_div),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .res_valid (core_valid),
    .res_hi    (core_hi),
    .res_lo    (core_lo)
  );

  // Sign fix-up. Most-negative / -1 needs no special case: the magnitude
  // quotient is 2^(DW-1), which reads back as the most-negative value.
  // For a zero divisor the core already returns |a| as remainder, and the
  // remainder sign fix restores the original dividend bits.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -core_lo : core_lo;
    rem = rem_neg_q ? -core_hi : core_hi;
    if (div_zero_q) quo = '1;
`ifdef HILO_MUL_ACC_EN
    // Base is the HI/LO value held at the completion edge, so MTHI/MTLO
    // issued while busy feed the accumulation.
    acc_val = sub_q ? ({hi_o, lo_o} - prod) : ({hi_o, lo_o} + prod);
    if (acc_q) prod = acc_val;
`endif
    if (state_q == ST_DIV) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*DW-1:DW];
      res_lo = prod[DW-1:0];
    end
  end

  // cancel freezes HI/LO for the edge; completion overrides MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (!cancel) begin
      if (complete) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end else begin
        if (whi) hi_o <= hi_i;
        if (wlo) lo_o <= lo_i;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;
  import hilo_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          cancel;
  logic          whi;
  logic          wlo;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic          busy;
  logic          done;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  int c;
  int extra;

  hilo_muldiv #(.DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .whi    (whi),
    .wlo    (wlo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .busy   (busy),
    .done   (done),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int cyc;
    issue(o, a, b);
    count_busy(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'd32);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hi"}, hi_o, exp_hi);
    check({tag, "_lo"}, lo_o, exp_lo);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    cancel = 1'b0; whi = 1'b0; wlo = 1'b0; hi_i = '0; lo_i = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    run_check("mult",  OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_check("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    run_check("divu",  OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
    run_check("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_check("divu_z", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_check("div_z",  OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // Second start while busy is ignored; operands are latched.
    issue(OP_MULTU, 32'd6, 32'd7);
    c = 0;
    while (busy && c < 100) begin
      c++;
      start = (c == 5); op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
    end
    start = 1'b0;
    check("restart_lat", 32'(c), 32'd32);
    check("restart_lo", lo_o, 32'd42);
    check("restart_hi", hi_o, 32'd0);
    extra = 0;
    @(negedge clk);
    repeat (40) begin
      if (busy || done) extra++;
      @(negedge clk);
    end
    check("restart_single", 32'(extra), 32'd0);

    // Cancel mid-operation.
    issue(OP_DIVU, 32'd100, 32'd7);
    c = 0;
    while (busy && c < 100) begin
      c++;
      cancel = (c == 10);
      @(negedge clk);
    end
    cancel = 1'b0;
    check("cancel_busy_drop", 32'(c), 32'd10);
    extra = 0;
    repeat (40) begin
      if (busy || done) extra++;
      @(negedge clk);
    end
    check("cancel_no_done", 32'(extra), 32'd0);
    check("cancel_hi", hi_o, 32'd0);
    check("cancel_lo", lo_o, 32'd42);

    // MTHI/MTLO while idle.
    whi = 1'b1; wlo = 1'b1; hi_i = 32'h1234; lo_i = 32'h5678;
    @(negedge clk);
    whi = 1'b0; wlo = 1'b0;
    check("mt_hi", hi_o, 32'h1234);
    check("mt_lo", lo_o, 32'h5678);

    // MTLO during busy is visible; MTHI on the completion edge loses.
    issue(OP_MULTU, 32'd6, 32'd7);
    c = 0;
    while (busy && c < 100) begin
      c++;
      if (c == 4) check("mt_busy_lo", lo_o, 32'hBEEF);
      wlo = (c == 3); lo_i = 32'hBEEF;
      whi = (c == 32); hi_i = 32'hAAAA;
      @(negedge clk);
    end
    whi = 1'b0; wlo = 1'b0;
    check("mt_race_done", 32'(done), 32'd1);
    check("mt_race_hi", hi_o, 32'd0);
    check("mt_race_lo", lo_o, 32'd42);

    // Asynchronous reset mid-divide.
    run_check("pre_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_hi", hi_o, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Accumulate ops.
    @(negedge clk);
    whi = 1'b1; wlo = 1'b1; hi_i = 32'd0; lo_i = 32'd10;
    @(negedge clk);
    whi = 1'b0; wlo = 1'b0;
`ifdef HILO_MUL_ACC_EN
    run_check("madd", OP_MADD, 32'd3, 32'd4, 32'd0, 32'd22);
    run_check("msub", OP_MSUB, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    issue(OP_MADD, 32'd3, 32'd4);
    check("acc_off_busy", 32'(busy), 32'd0);
    extra = 0;
    repeat (40) begin
      if (busy || done) extra++;
      @(negedge clk);
    end
    check("acc_off_idle", 32'(extra), 32'd0);
    check("acc_off_hi", hi_o, 32'd0);
    check("acc_off_lo", lo_o, 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Parametrised successor to the HI/LO register pair.
- Adds an iterative multiply/divide engine that writes HI/LO on completion.
- Provides independent MTHI/MTLO write enables, busy/done handshake and pipeline-flush cancel.
- Sits in the arithmetic stage beside the ALU; the pipeline stalls on busy when a MFHI/MFLO or new mul/div issues.

Parameters:
DW, 32, operand and HI/LO width; valid DW >= 4, even.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  issue operation; sampled only when accepted (state IDLE or DONE).
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate ops (optional feature).
src_a  input  DW  multiplicand / dividend.
src_b  input  DW  multiplier / divisor.
cancel  input  1  flush: abort the in-flight operation.
whi  input  1  MTHI write enable.
wlo  input  1  MTLO write enable.
hi_i  input  DW  MTHI data.
lo_i  input  DW  MTLO data.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; HI/LO hold the new result.
hi_o  output  DW  HI register.
lo_o  output  DW  LO register.

Behaviour:
- Reset (asynchronous, active-high):
  - hi_o = 0, lo_o = 0, busy = 0, done = 0, state = IDLE, iteration counter = 0.
  - Reset asserted mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + start + op valid -> MUL (op 00x, 1xx) or DIV (op 01x). Operands are latched at that edge.
  - MUL/DIV -> DONE after exactly DW iterations, one per cycle. HI/LO are loaded on that same edge.
  - DONE -> IDLE unless a new start is accepted.
  - Any state + cancel -> IDLE on the next edge. hi_o/lo_o are unchanged and no done pulse occurs.
- Latency and handshake:
  - busy = 1 in MUL/DIV: exactly DW cycles after the accepting edge.
  - done = 1 only in DONE: cycle DW+1.
  - start while busy is ignored.
  - start together with cancel is ignored.
- Multiply:
  - Signed ops use operand magnitudes; the 2*DW product is negated when sign(a) ^ sign(b).
  - HI = product[2DW-1:DW], LO = product[DW-1:0].
- Divide:
  - Restoring algorithm on magnitudes. LO = quotient, HI = remainder.
  - Signed: quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
  - Overflow, most-negative / -1: LO = most-negative, HI = 0 (wrap, no trap).
  - Divide by zero (full latency, no trap): LO = all ones, HI = src_a, for both signed and unsigned.
- MTHI/MTLO:
  - whi/wlo write hi_o/lo_o at the next edge in any state. Each enable is independent.
  - Completion write wins over whi/wlo on the same edge.
  - A write during busy is visible until overwritten at completion.
- Priority per edge: reset > cancel > completion > whi/wlo.

Optional Feature:
HILO_MUL_ACC_EN
- Enabled:
  - op 100 MADD, 101 MADDU: {HI,LO} = {HI,LO} + product.
  - op 110 MSUB, 111 MSUBU: {HI,LO} = {HI,LO} - product.
  - Sum/difference is modulo 2^(2DW).
  - The accumulator base is hi_o/lo_o as held at the completion edge, so MTHI/MTLO during busy takes effect.
- Disabled: start with op[2] = 1 is ignored (no busy, no done, HI/LO unchanged).

Decomposition:
- Package hilo_pkg: op encodings (OP_MULT..OP_MSUBU), state encodings, op-width constant.
- One sub-module, hilo_iter_core: shift/add multiply and restoring-divide datapath with iteration counter, DW-parametrised.
  - It exposes a one-cycle result-valid pulse to the top level.
  - The top level owns the FSM, sign fix-up, accumulation and the HI/LO registers.

Test Plan:
1. MULT, a = 0xFFFFFFFE, b = 3 -> busy 32 cycles, done in cycle 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. MULTU on the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
2. DIVU 100 / 7 -> lo = 14, hi = 2. DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
3. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU 5 / 0 -> lo = 0xFFFFFFFF, hi = 5, after full latency.
4. Second start at busy cycle 5 -> ignored, single done. cancel at busy cycle 10 -> busy = 0 next cycle, no done, hi/lo keep prior values.
5. Idle, whi = 1, wlo = 1, hi_i = 0x1234, lo_i = 0x5678 -> values appear next cycle. Then whi asserted on the completion edge -> hi_o = mul result.
6. reset pulsed mid-DIV -> hi_o = lo_o = 0 and busy = 0 immediately. With HILO_MUL_ACC_EN: HI:LO = 0:10, MADD 3 x 4 -> lo = 22; MSUB 5 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFD.
